operand_forward_unit: RTL and testbench

OPERAND_FORWARD_UNIT -- requirements
Module: operand_forward_unit

---
 rtl/operand_forward_unit.sv | 181 ++++++++++++++++++
 tb/tb_operand_forward_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_forward_unit.sv
// Operand forwarding and load-use stall unit for a 5-stage RISC-V pipeline.
// Optional perf counters (fwd_cnt, stall_cnt) enabled by FWD_PERF_CNT_EN.
module operand_forward_unit #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_we,
  input  logic              id_load,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              flush,
  input  logic [DATA_W-1:0] rf_a_ex,
  input  logic [DATA_W-1:0] rf_b_ex,
  input  logic [DATA_W-1:0] alu_out_d2,
  input  logic [DATA_W-1:0] alu_out_d3,
  input  logic [DATA_W-1:0] dout_d3,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              stall
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]       fwd_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              load;
    logic [REG_AW-1:0] rd;
  } slot_t;

  typedef struct packed {
    slot_t             s;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use1;
    logic              use2;
  } ex_t;

  ex_t               ex_q, ex_d;
  slot_t             mem_q, wb_q;
  logic              ret_v_q, ret_we_q;
  logic [REG_AW-1:0] ret_rd_q;
  logic [DATA_W-1:0] ret_data_q, ret_data_d;
  logic [DATA_W-1:0] wb_data;
  logic              lu_a, lu_b;

  function automatic logic hit(
    input logic              v,
    input logic              we,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] rs
  );
    return v && we && (rd == rs) &&
           !((ZERO_REG != 0) && (rs == '0));
  endfunction

  // Newest producer wins; a load still in MEM has no data yet.
  function automatic logic [1:0] pick(
    input logic              rd_en,
    input logic [REG_AW-1:0] rs,
    input slot_t             m,
    input slot_t             w,
    input logic              rv,
    input logic              rwe,
    input logic [REG_AW-1:0] rrd
  );
    if (!rd_en)
      return 2'd0;
    if (hit(m.valid, m.we, m.rd, rs) && !m.load)
      return 2'd1;
    if (hit(w.valid, w.we, w.rd, rs))
      return 2'd2;
    if (hit(rv, rwe, rrd, rs))
      return 2'd3;
    return 2'd0;
  endfunction

  always_comb begin
    wb_data    = wb_q.load ? dout_d3 : alu_out_d3;
    ret_data_d = wb_data;
    sel_a = pick(ex_q.s.valid && ex_q.use1, ex_q.rs1,
                 mem_q, wb_q, ret_v_q, ret_we_q, ret_rd_q);
    sel_b = pick(ex_q.s.valid && ex_q.use2, ex_q.rs2,
                 mem_q, wb_q, ret_v_q, ret_we_q, ret_rd_q);
    unique case (sel_a)
      2'd1:    ex_op_a = alu_out_d2;
      2'd2:    ex_op_a = wb_data;
      2'd3:    ex_op_a = ret_data_q;
      default: ex_op_a = rf_a_ex;
    endcase
    unique case (sel_b)
      2'd1:    ex_op_b = alu_out_d2;
      2'd2:    ex_op_b = wb_data;
      2'd3:    ex_op_b = ret_data_q;
      default: ex_op_b = rf_b_ex;
    endcase
  end

  always_comb begin
    lu_a = id_use_rs1 &&
           hit(ex_q.s.valid && ex_q.s.load, ex_q.s.we,
               ex_q.s.rd, id_rs1);
    lu_b = id_use_rs2 &&
           hit(ex_q.s.valid && ex_q.s.load, ex_q.s.we,
               ex_q.s.rd, id_rs2);
    stall = id_valid && (lu_a || lu_b);
  end

  always_comb begin
    ex_d         = ex_q;
    ex_d.s.valid = 1'b0;
    if (!stall && !flush) begin
      ex_d.s.valid = id_valid;
      ex_d.s.we    = id_we;
      ex_d.s.load  = id_load;
      ex_d.s.rd    = id_rd;
      ex_d.rs1     = id_rs1;
      ex_d.rs2     = id_rs2;
      ex_d.use1    = id_use_rs1;
      ex_d.use2    = id_use_rs2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      ret_v_q    <= 1'b0;
      ret_we_q   <= 1'b0;
      ret_rd_q   <= '0;
      ret_data_q <= '0;
    end else begin
      ex_q       <= ex_d;
      mem_q      <= ex_q.s;
      wb_q       <= mem_q;
      ret_v_q    <= wb_q.valid;
      ret_we_q   <= wb_q.we;
      ret_rd_q   <= wb_q.rd;
      ret_data_q <= ret_data_d;
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] fwd_cnt_q, fwd_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [1:0]  fwd_inc;

  always_comb begin
    fwd_inc     = {1'b0, |sel_a} + {1'b0, |sel_b};
    fwd_cnt_d   = fwd_cnt_q + {30'd0, fwd_inc};
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_cnt   = fwd_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_forward_unit.sv
// Bench for operand_forward_unit: directed hazard cases plus random
// instruction streams checked against an in-flight instruction model.
module tb_operand_forward_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid, id_we, id_load;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, flush;
  logic [31:0] rf_a_ex, rf_b_ex, alu_out_d2, alu_out_d3, dout_d3;
  logic [31:0] ex_op_a, ex_op_b;
  logic [1:0]  sel_a, sel_b;
  logic        stall;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] fwd_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  operand_forward_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_we      (id_we),
    .id_load    (id_load),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rd      (id_rd),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .flush      (flush),
    .rf_a_ex    (rf_a_ex),
    .rf_b_ex    (rf_b_ex),
    .alu_out_d2 (alu_out_d2),
    .alu_out_d3 (alu_out_d3),
    .dout_d3    (dout_d3),
    .ex_op_a    (ex_op_a),
    .ex_op_b    (ex_op_b),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .stall      (stall)
`ifdef FWD_PERF_CNT_EN
    ,
    .fwd_cnt    (fwd_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  typedef struct {
    bit v, we, ld, u1, u2;
    int rd, rs1, rs2;
  } ins_t;

  ins_t        m_ex, m_mem, m_wb, m_ret;
  logic [31:0] m_ret_d;
  int unsigned m_fwd, m_stc;
  int          n_chk = 0;
  int          n_err = 0;
  bit          last_st;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit wr(ins_t r, int rs);
    return r.v && r.we && r.rd == rs && rs != 0;
  endfunction

  function automatic int src(int rs, bit u);
    if (!m_ex.v || !u) return 0;
    if (wr(m_mem, rs) && !m_mem.ld) return 1;
    if (wr(m_wb, rs)) return 2;
    if (wr(m_ret, rs)) return 3;
    return 0;
  endfunction

  function automatic logic [31:0] val(int s, logic [31:0] rf);
    case (s)
      1: return alu_out_d2;
      2: return m_wb.ld ? dout_d3 : alu_out_d3;
      3: return m_ret_d;
      default: return rf;
    endcase
  endfunction

  function automatic bit exp_stall();
    bit a, b;
    a = id_use_rs1 && int'(id_rs1) == m_ex.rd && id_rs1 != 0;
    b = id_use_rs2 && int'(id_rs2) == m_ex.rd && id_rs2 != 0;
    return id_valid && m_ex.v && m_ex.ld && m_ex.we && (a || b);
  endfunction

  task automatic model_clear();
    ins_t z;
    z = '{default: 0};
    m_ex = z; m_mem = z; m_wb = z; m_ret = z;
    m_ret_d = '0;
    m_fwd = 0;
    m_stc = 0;
    last_st = 0;
  endtask

  task automatic check_all();
    int sa, sb;
    sa = src(m_ex.rs1, m_ex.u1);
    sb = src(m_ex.rs2, m_ex.u2);
    chk("sel_a", sel_a, sa);
    chk("sel_b", sel_b, sb);
    chk("ex_op_a", ex_op_a, val(sa, rf_a_ex));
    chk("ex_op_b", ex_op_b, val(sb, rf_b_ex));
    chk("stall", stall, exp_stall());
`ifdef FWD_PERF_CNT_EN
    chk("fwd_cnt", fwd_cnt, m_fwd);
    chk("stall_cnt", stall_cnt, m_stc);
`endif
  endtask

  task automatic advance();
    bit   st;
    int   sa, sb;
    ins_t nx;
    st = exp_stall();
    sa = src(m_ex.rs1, m_ex.u1);
    sb = src(m_ex.rs2, m_ex.u2);
    m_fwd += (sa != 0 ? 1 : 0) + (sb != 0 ? 1 : 0);
    m_stc += st ? 1 : 0;
    m_ret_d = m_wb.ld ? dout_d3 : alu_out_d3;
    m_ret = m_wb;
    m_wb  = m_mem;
    m_mem = m_ex;
    nx = '{default: 0};
    if (!st && !flush) begin
      nx.v = id_valid; nx.we = id_we; nx.ld = id_load;
      nx.rd = int'(id_rd);
      nx.rs1 = int'(id_rs1); nx.rs2 = int'(id_rs2);
      nx.u1 = id_use_rs1; nx.u2 = id_use_rs2;
    end
    m_ex = nx;
    last_st = st;
  endtask

  task automatic tick();
    #1;
    check_all();
    advance();
    @(negedge clk);
  endtask

  task automatic rnd_data();
    rf_a_ex    = $urandom;
    rf_b_ex    = $urandom;
    alu_out_d2 = $urandom;
    alu_out_d3 = $urandom;
    dout_d3    = $urandom;
  endtask

  task automatic set_id(bit v, bit we, bit ld, int rs1, int rs2,
                        int rd, bit u1, bit u2);
    id_valid = v; id_we = we; id_load = ld;
    id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
    id_use_rs1 = u1; id_use_rs2 = u2;
    flush = 1'b0;
  endtask

  initial begin
    rnd_data();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_sel_a", sel_a, 0);
    chk("rst_sel_b", sel_b, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // add r3 ; add r4,r3,r3
    rnd_data(); set_id(1, 1, 0, 1, 2, 3, 1, 1); tick();
    rnd_data(); set_id(1, 1, 0, 3, 3, 4, 1, 1); tick();
    rnd_data(); alu_out_d2 = 32'h10;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("raw_sel_a", sel_a, 1);
    chk("raw_sel_b", sel_b, 1);
    chk("raw_op_a", ex_op_a, 32'h10);
    chk("raw_op_b", ex_op_b, 32'h10);
    tick();

    // lw r5 ; add r6,r5,r1
    rnd_data(); set_id(1, 1, 1, 0, 0, 5, 0, 0); tick();
    rnd_data(); set_id(1, 1, 0, 5, 1, 6, 1, 1);
    #1; chk("lu_stall", stall, 1);
    tick();
    rnd_data(); #1; chk("lu_stall_1cyc", stall, 0);
    tick();
    rnd_data(); dout_d3 = 32'hDEAD_BEEF;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("lu_sel_a", sel_a, 2);
    chk("lu_op_a", ex_op_a, 32'hDEAD_BEEF);
    tick();

    // r7 written twice, newest in MEM wins
    rnd_data(); set_id(1, 1, 0, 0, 0, 7, 0, 0); tick();
    rnd_data(); set_id(1, 1, 0, 0, 0, 7, 0, 0); tick();
    rnd_data(); set_id(1, 1, 0, 7, 7, 8, 1, 1); tick();
    rnd_data(); alu_out_d2 = 32'h1; alu_out_d3 = 32'h2;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("prio_sel_a", sel_a, 1);
    chk("prio_op_a", ex_op_a, 32'h1);
    tick();

    // r0 never forwarded or stalled on
    rnd_data(); set_id(1, 1, 0, 0, 0, 0, 0, 0); tick();
    rnd_data(); set_id(1, 1, 0, 0, 0, 9, 1, 1); tick();
    rnd_data(); set_id(1, 1, 1, 0, 0, 0, 0, 0);
    #1;
    chk("r0_sel_a", sel_a, 0);
    chk("r0_op_a", ex_op_a, rf_a_ex);
    tick();
    rnd_data(); set_id(1, 1, 0, 0, 0, 10, 1, 1);
    #1; chk("r0_nostall", stall, 0);
    tick();

    // reset with load-use pending
    rnd_data(); set_id(1, 1, 1, 0, 0, 5, 0, 0); tick();
    rnd_data(); set_id(1, 1, 0, 5, 1, 6, 1, 1);
    #1; chk("pre_rst_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_sel_a", sel_a, 0);
    chk("mid_rst_sel_b", sel_b, 0);
`ifdef FWD_PERF_CNT_EN
    chk("mid_rst_fcnt", fwd_cnt, 0);
    chk("mid_rst_scnt", stall_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 500; i++) begin
      rnd_data();
      if (!last_st) begin
        id_valid   = ($urandom_range(0, 99) < 85);
        id_we      = ($urandom_range(0, 99) < 70);
        id_load    = ($urandom_range(0, 99) < 30);
        id_rs1     = 5'($urandom_range(0, 3));
        id_rs2     = 5'($urandom_range(0, 3));
        id_rd      = 5'($urandom_range(0, 3));
        id_use_rs1 = $urandom_range(0, 1) != 0;
        id_use_rs2 = $urandom_range(0, 1) != 0;
      end
      flush = ($urandom_range(0, 99) < 10);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
